// File: rtl/pkt_blk_asm.sv
// pkt_blk_asm: collects NPKT position-tagged packets into one block.
// Ports: clk, reset (async, active-high);
//   data = {pos, payload}, avl (packet valid), flush (abort block);
//   blk_rdy (downstream accepts); in_rdy (packet can be taken);
//   blk (slot k at [k*PKT_W +: PKT_W]), blk_vld (block complete);
//   rcv_cnt (distinct slots filled); dup_err and ovf_err (drop pulses).
module pkt_blk_asm #(
    parameter int PKT_W = 29,
    parameter int NPKT  = 16,
    parameter int POS_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [POS_W+PKT_W-1:0]  data,
    input  logic                    avl,
    input  logic                    flush,
    input  logic                    blk_rdy,
    output logic                    in_rdy,
    output logic [NPKT*PKT_W-1:0]   blk,
    output logic                    blk_vld,
    output logic [POS_W:0]          rcv_cnt,
    output logic                    dup_err,
    output logic                    ovf_err
);

    typedef enum logic {FILL, FULL} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NPKT-1:0]   mask;
    logic [NPKT-1:0]   mask_nxt;
    logic [POS_W:0]    cnt_nxt;
    logic              wr;
    logic              dup;
    logic              ovf;
    logic [POS_W-1:0]  pos;
    logic [PKT_W-1:0]  pld;

    assign pos     = data[POS_W+PKT_W-1 -: POS_W];
    assign pld     = data[PKT_W-1:0];
    assign in_rdy  = (state == FILL);
    assign blk_vld = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FILL;
            mask    <= '0;
            rcv_cnt <= '0;
            dup_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            mask    <= mask_nxt;
            rcv_cnt <= cnt_nxt;
            dup_err <= dup;
            ovf_err <= ovf;
        end
    end

    // flush wins over everything; a packet offered while FULL is
    // dropped even when the handshake happens in the same cycle.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        cnt_nxt   = rcv_cnt;
        wr        = 1'b0;
        dup       = 1'b0;
        ovf       = 1'b0;
        if (flush) begin
            state_nxt = FILL;
            mask_nxt  = '0;
            cnt_nxt   = '0;
        end else if (state == FILL) begin
            if (avl) begin
                if (mask[pos]) begin
                    dup = 1'b1;
                end else begin
                    wr            = 1'b1;
                    mask_nxt[pos] = 1'b1;
                    cnt_nxt       = rcv_cnt + 1'b1;
                    if (rcv_cnt == (POS_W+1)'(NPKT-1))
                        state_nxt = FULL;
                end
            end
        end else begin
            ovf = avl;
            if (blk_rdy) begin
                state_nxt = FILL;
                mask_nxt  = '0;
                cnt_nxt   = '0;
            end
        end
    end

    // Buffer is only cleared by reset; stale slots are masked by state.
    for (genvar k = 0; k < NPKT; k++) begin : g_slot
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                blk[k*PKT_W +: PKT_W] <= '0;
            else if (wr && pos == POS_W'(k))
                blk[k*PKT_W +: PKT_W] <= pld;
        end
    end

endmodule

// File: tb/tb_pkt_blk_asm.sv
// tb_pkt_blk_asm: directed self-checking bench for pkt_blk_asm,
// default configuration plus a 4 x 8-bit instance.
module tb_pkt_blk_asm;

    localparam int PW = 29;
    localparam int NP = 16;
    localparam int PS = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [PS+PW-1:0]  data = '0;
    logic              avl = 1'b0;
    logic              flush = 1'b0;
    logic              blk_rdy = 1'b0;
    logic              in_rdy;
    logic [NP*PW-1:0]  blk;
    logic              blk_vld;
    logic [PS:0]       rcv_cnt;
    logic              dup_err;
    logic              ovf_err;

    logic [9:0]        data2 = '0;
    logic              avl2 = 1'b0;
    logic              flush2 = 1'b0;
    logic              blk_rdy2 = 1'b0;
    logic              in_rdy2;
    logic [31:0]       blk2;
    logic              blk_vld2;
    logic [2:0]        rcv_cnt2;
    logic              dup_err2;
    logic              ovf_err2;

    logic [NP*PW-1:0]  exp_blk;
    int                n_run = 0;
    int                n_fail = 0;

    pkt_blk_asm dut (
        .clk(clk), .reset(reset), .data(data), .avl(avl),
        .flush(flush), .blk_rdy(blk_rdy), .in_rdy(in_rdy),
        .blk(blk), .blk_vld(blk_vld), .rcv_cnt(rcv_cnt),
        .dup_err(dup_err), .ovf_err(ovf_err)
    );

    pkt_blk_asm #(.PKT_W(8), .NPKT(4), .POS_W(2)) dut2 (
        .clk(clk), .reset(reset), .data(data2), .avl(avl2),
        .flush(flush2), .blk_rdy(blk_rdy2), .in_rdy(in_rdy2),
        .blk(blk2), .blk_vld(blk_vld2), .rcv_cnt(rcv_cnt2),
        .dup_err(dup_err2), .ovf_err(ovf_err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [PW-1:0] v);
        data = {p[PS-1:0], v};
        avl  = 1'b1;
        tick();
        avl  = 1'b0;
    endtask

    task automatic put2(input int p, input logic [7:0] v);
        data2 = {p[1:0], v};
        avl2  = 1'b1;
        tick();
        avl2  = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_cnt"}, 512'(rcv_cnt), 512'(0));
        chk({tag, "_blk"}, 512'(blk), 512'(0));
        chk({tag, "_vld"}, 512'(blk_vld), 512'(0));
        chk({tag, "_rdy"}, 512'(in_rdy), 512'(1));
        chk({tag, "_dup"}, 512'(dup_err), 512'(0));
        chk({tag, "_ovf"}, 512'(ovf_err), 512'(0));
    endtask

    initial begin
        #2;
        chk_rst("rst");
        tick();
        reset = 1'b0;
        tick();

        // full block, descending positions
        exp_blk = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            put(i, PW'(32'h1000000 + i));
            exp_blk[i*PW +: PW] = PW'(32'h1000000 + i);
            if (i == 1)
                chk("pre_full_vld", 512'(blk_vld), 512'(0));
        end
        chk("full_vld", 512'(blk_vld), 512'(1));
        chk("full_cnt", 512'(rcv_cnt), 512'(16));
        chk("full_rdy", 512'(in_rdy), 512'(0));
        chk("full_blk", 512'(blk), 512'(exp_blk));

        // overflow while full, then handshake
        for (int j = 0; j < 3; j++) begin
            put(5, PW'(32'h5555));
            chk("ovf_pulse", 512'(ovf_err), 512'(1));
            chk("ovf_dup", 512'(dup_err), 512'(0));
            chk("ovf_blk", 512'(blk), 512'(exp_blk));
            chk("ovf_vld", 512'(blk_vld), 512'(1));
        end
        blk_rdy = 1'b1;
        tick();
        blk_rdy = 1'b0;
        chk("hs_vld", 512'(blk_vld), 512'(0));
        chk("hs_cnt", 512'(rcv_cnt), 512'(0));
        chk("hs_rdy", 512'(in_rdy), 512'(1));
        chk("hs_ovf", 512'(ovf_err), 512'(0));

        // duplicate slot
        put(3, PW'(32'hAA));
        chk("dup_first", 512'(dup_err), 512'(0));
        chk("dup_cnt1", 512'(rcv_cnt), 512'(1));
        put(3, PW'(32'hBB));
        chk("dup_pulse", 512'(dup_err), 512'(1));
        chk("dup_cnt2", 512'(rcv_cnt), 512'(1));
        tick();
        chk("dup_end", 512'(dup_err), 512'(0));
        chk("dup_slot", 512'(blk[3*PW +: PW]), 512'(32'hAA));

        // flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl0_cnt", 512'(rcv_cnt), 512'(0));
        blk_rdy = 1'b1;
        for (int k = 0; k < 10; k++)
            put(k, PW'(32'h100 + k));
        blk_rdy = 1'b0;
        chk("fl10_cnt", 512'(rcv_cnt), 512'(10));
        chk("fl10_rdy", 512'(in_rdy), 512'(1));
        data  = {4'd11, PW'(32'h7777)};
        avl   = 1'b1;
        flush = 1'b1;
        tick();
        avl   = 1'b0;
        flush = 1'b0;
        chk("fl_cnt", 512'(rcv_cnt), 512'(0));
        chk("fl_dup", 512'(dup_err), 512'(0));
        chk("fl_ovf", 512'(ovf_err), 512'(0));
        for (int k = 0; k < NP; k++) begin
            put(k, PW'(32'h200 + k));
            exp_blk[k*PW +: PW] = PW'(32'h200 + k);
        end
        chk("fl_new_vld", 512'(blk_vld), 512'(1));
        chk("fl_new_cnt", 512'(rcv_cnt), 512'(16));
        chk("fl_new_dup", 512'(dup_err), 512'(0));
        chk("fl_new_blk", 512'(blk), 512'(exp_blk));
        blk_rdy = 1'b1;
        tick();
        blk_rdy = 1'b0;

        // async reset mid-block
        for (int k = 0; k < 7; k++)
            put(k, PW'(32'h300 + k));
        chk("pre_rst_cnt", 512'(rcv_cnt), 512'(7));
        reset = 1'b1;
        #1;
        chk_rst("arst");
        #1;
        reset = 1'b0;
        tick();
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (k * 5) % NP;
            put(p, PW'(32'h400 + p));
            exp_blk[p*PW +: PW] = PW'(32'h400 + p);
        end
        chk("post_rst_vld", 512'(blk_vld), 512'(1));
        chk("post_rst_blk", 512'(blk), 512'(exp_blk));

        // small configuration
        put2(2, 8'h22);
        put2(0, 8'h00);
        put2(3, 8'h33);
        chk("s_pre_vld", 512'(blk_vld2), 512'(0));
        chk("s_pre_cnt", 512'(rcv_cnt2), 512'(3));
        put2(1, 8'h11);
        chk("s_vld", 512'(blk_vld2), 512'(1));
        chk("s_blk", 512'(blk2), 512'(32'h33221100));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_blk_asm.md
PKT_BLK_ASM -- requirements
Module: pkt_blk_asm

Interface
REQ-001 Parameter PKT_W, default 29, packet payload width in bits.
REQ-002 Parameter NPKT, default 16, packets per block; power of two, 2..256.
REQ-003 Parameter POS_W, default 4, position field width; SHALL equal log2(NPKT).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data  input  POS_W+PKT_W  [POS_W+PKT_W-1 -: POS_W] = slot position, [PKT_W-1:0] = payload.
REQ-007 avl  input  1  data valid this cycle.
REQ-008 flush  input  1  synchronous abort of the current block.
REQ-009 blk_rdy  input  1  downstream accepts block.
REQ-010 in_rdy  output  1  module can accept a packet.
REQ-011 blk  output  NPKT*PKT_W  assembled block; slot k at [k*PKT_W +: PKT_W].
REQ-012 blk_vld  output  1  blk complete and stable.
REQ-013 rcv_cnt  output  POS_W+1  distinct slots filled in current block.
REQ-014 dup_err  output  1  one-cycle pulse: duplicate packet dropped.
REQ-015 ovf_err  output  1  one-cycle pulse: packet offered while full, dropped.

Function
REQ-016 Two states: FILL (in_rdy=1, blk_vld=0) and FULL (in_rdy=0, blk_vld=1).
REQ-017 Accept = avl & in_rdy & ~flush; accepted packet writes payload to slot pos and sets mask[pos] at the next edge.
REQ-018 Packet with avl=1 in FILL and mask[pos]=1: payload dropped, buffer/mask/count unchanged, dup_err=1 the following cycle.
REQ-019 rcv_cnt increments by exactly 1 per accepted non-duplicate packet; never exceeds NPKT.
REQ-020 Accepting the packet that makes rcv_cnt reach NPKT moves FILL->FULL at the same edge; blk_vld=1 from the next cycle (latency 1 from last packet).
REQ-021 In FULL, blk and blk_vld SHALL hold stable until handshake blk_vld & blk_rdy.
REQ-022 On handshake: FULL->FILL, mask and rcv_cnt cleared at that edge; in_rdy=1 next cycle.
REQ-023 avl=1 in FULL without handshake: packet dropped, ovf_err=1 next cycle; avl with handshake in the same cycle is also dropped (no bypass).
REQ-024 flush=1 in any state: mask and rcv_cnt cleared, state -> FILL at next edge; flush has priority over avl and handshake; no error pulses for that cycle.
REQ-025 blk buffer contents are not cleared by handshake or flush; only meaningful when blk_vld=1.
REQ-026 Slots arrive in any order; slot position is the only placement key.
REQ-027 blk_rdy while blk_vld=0 has no effect.
REQ-028 dup_err and ovf_err never assert in the same cycle.

Reset
REQ-029 reset=1 asynchronously forces: state FILL, mask=0, rcv_cnt=0, blk=0, blk_vld=0, in_rdy=1, dup_err=0, ovf_err=0.
REQ-030 Reset mid-block discards all partial data; first packet after release starts a new block.

Verification
REQ-031 Defaults; send pos 15..0 descending, payload = 0x1000000+pos, blk_rdy=0 -> blk_vld=1 one cycle after pos 0, each slot k = 0x1000000+k, rcv_cnt=16, in_rdy=0.
REQ-032 Send pos 3 payload 0xAA then pos 3 payload 0xBB -> dup_err pulse 1 cycle, slot 3 stays 0xAA, rcv_cnt=1.
REQ-033 Full block, blk_rdy=0, avl pos 5 for 3 cycles -> ovf_err pulse each cycle, blk unchanged; then blk_rdy=1 one cycle -> blk_vld=0, rcv_cnt=0, in_rdy=1 next cycle.
REQ-034 Send 10 distinct packets, assert flush with avl=1 pos 11 -> rcv_cnt=0, packet 11 not counted, then 16 new packets complete a block normally.
REQ-035 Assert reset after 7 packets -> all outputs at reset values immediately, without a clock edge; 16 packets after release yield blk_vld.
REQ-036 NPKT=4, PKT_W=8, POS_W=2: pos 2,0,3,1 with payloads 0x22,0x00,0x33,0x11 -> blk=0x33221100, blk_vld after 4th packet.
